// File: rtl/bidir_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bidir_bus_ctrl_pkg
// Brief   : Shared types and constants for the half-duplex bus controller.
// Revision: 1.0 - initial release
// ============================================================================
package bidir_bus_ctrl_pkg;

  // Default data width of the shared bus
  localparam int DEFAULT_DATA_W = 8;

  // Controller state encoding
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_TURN   = 2'd2,
    S_SAMPLE = 2'd3
  } state_t;

  // Larger of two integers; used to size the shared window counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bidir_bus_ctrl_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module  : bus_cycle_counter
// Brief   : Loadable down-counter with a done flag (count == 1), shared by the
//           drive-hold and bus-turnaround windows.
// Revision: 1.0 - initial release
// ============================================================================
module bus_cycle_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on state entry, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Final cycle of the current window
  assign done = (cnt == W'(1));

endmodule
`default_nettype wire

// File: rtl/bidir_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bidir_bus_ctrl
// Brief   : Half-duplex controller for a shared tri-state bus. Drives the pad
//           buffer enable/data, samples the pad return value, and enforces
//           drive-hold and turnaround windows so drivers never contend.
// Revision: 1.0 - initial release
// ============================================================================
module bidir_bus_ctrl
  import bidir_bus_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int HOLD_CYC = 1,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din,
  output logic              busy
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYC, TURN_CYC) + 1);
  localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] C_TURN = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           state;
  logic             is_read;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid & req_ready;

  // Reload the window counter whenever the FSM enters a new state
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          cnt_val  = req_write ? C_HOLD : C_TURN;
        end
      end
      S_DRIVE: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = C_TURN;
        end
      end
      S_TURN: begin
        if (cnt_done) begin
          cnt_load = 1'b1;
          cnt_val  = is_read ? C_ONE : '0;
        end
      end
      default: begin
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
    endcase
  end

  bus_cycle_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Transaction FSM with registered bus and response outputs; the async
  // reset releases the bus immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      is_read   <= 1'b0;
      bus_oe    <= 1'b0;
      bus_dout  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            is_read <= ~req_write;
            if (req_write) begin
              state    <= S_DRIVE;
              bus_oe   <= 1'b1;
              bus_dout <= req_wdata;
            end else begin
              state <= S_TURN;
            end
          end
        end
        S_DRIVE: begin
          if (cnt_done) begin
            state  <= S_TURN;
            bus_oe <= 1'b0;
          end
        end
        S_TURN: begin
          if (cnt_done) begin
            state <= is_read ? S_SAMPLE : S_IDLE;
          end
        end
        default: begin
          rsp_rdata <= bus_din;
          rsp_valid <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bidir_bus_ctrl
// Brief   : Directed self-checking bench for bidir_bus_ctrl, default timing
//           instance plus a HOLD_CYC=3 / TURN_CYC=2 instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bidir_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // Instance A: default windows
  logic       a_req_valid = 1'b0;
  logic       a_req_ready;
  logic       a_req_write = 1'b0;
  logic [7:0] a_req_wdata = 8'h00;
  logic       a_rsp_valid;
  logic [7:0] a_rsp_rdata;
  logic       a_bus_oe;
  logic [7:0] a_bus_dout;
  logic [7:0] a_bus_din = 8'h00;
  logic       a_busy;

  // Instance B: HOLD_CYC=3, TURN_CYC=2
  logic       b_req_valid = 1'b0;
  logic       b_req_ready;
  logic       b_req_write = 1'b0;
  logic [7:0] b_req_wdata = 8'h00;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata;
  logic       b_bus_oe;
  logic [7:0] b_bus_dout;
  logic [7:0] b_bus_din = 8'h00;
  logic       b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bidir_bus_ctrl u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (a_req_write),
    .req_wdata (a_req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .bus_oe    (a_bus_oe),
    .bus_dout  (a_bus_dout),
    .bus_din   (a_bus_din),
    .busy      (a_busy)
  );

  bidir_bus_ctrl #(
    .DATA_W   (8),
    .HOLD_CYC (3),
    .TURN_CYC (2)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_wdata (b_req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .bus_oe    (b_bus_oe),
    .bus_dout  (b_bus_dout),
    .bus_din   (b_bus_din),
    .busy      (b_busy)
  );

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then show the new cycle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_oe",      a_bus_oe,    0);
    chk("rst_dout",    a_bus_dout,  8'h00);
    chk("rst_rspv",    a_rsp_valid, 0);
    chk("rst_rdata",   a_rsp_rdata, 8'h00);
    chk("rst_ready",   a_req_ready, 1);
    chk("rst_busy",    a_busy,      0);
    rst_n = 1'b1;
    step();

    // 1. Write A5 with default windows
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'hA5;
    step();
    a_req_valid = 1'b0; a_req_wdata = 8'h00;
    chk("w1_oe_k1",    a_bus_oe,    1);
    chk("w1_dout_k1",  a_bus_dout,  8'hA5);
    chk("w1_ready_k1", a_req_ready, 0);
    chk("w1_busy_k1",  a_busy,      1);
    step();
    chk("w1_oe_k2",    a_bus_oe,    0);
    chk("w1_dout_k2",  a_bus_dout,  8'hA5);
    chk("w1_ready_k2", a_req_ready, 0);
    step();
    chk("w1_ready_k3", a_req_ready, 1);
    chk("w1_busy_k3",  a_busy,      0);
    chk("w1_rspv_k3",  a_rsp_valid, 0);

    // 2. Read with pad value 3C
    a_bus_din = 8'h3C;
    a_req_valid = 1'b1; a_req_write = 1'b0;
    step();
    a_req_valid = 1'b0;
    chk("r2_oe_k1",    a_bus_oe,    0);
    chk("r2_ready_k1", a_req_ready, 0);
    step();
    chk("r2_oe_k2",    a_bus_oe,    0);
    chk("r2_rspv_k2",  a_rsp_valid, 0);
    step();
    chk("r2_rspv_k3",  a_rsp_valid, 1);
    chk("r2_rdata_k3", a_rsp_rdata, 8'h3C);
    chk("r2_ready_k3", a_req_ready, 1);
    chk("r2_oe_k3",    a_bus_oe,    0);
    step();
    chk("r2_rspv_k4",  a_rsp_valid, 0);
    chk("r2_rdata_k4", a_rsp_rdata, 8'h3C);

    // 4. Write 55 then read held behind it; then back-to-back write on rsp_valid
    a_bus_din = 8'hC3;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'h55;
    step();
    a_req_write = 1'b0;
    chk("wr4_oe_k1",    a_bus_oe,    1);
    chk("wr4_ready_k1", a_req_ready, 0);
    step();
    chk("wr4_oe_k2",    a_bus_oe,    0);
    chk("wr4_ready_k2", a_req_ready, 0);
    step();
    chk("wr4_oe_k3",    a_bus_oe,    0);
    chk("wr4_ready_k3", a_req_ready, 1);
    step();
    chk("wr4_rd_oe_1",    a_bus_oe,    0);
    chk("wr4_rd_ready_1", a_req_ready, 0);
    step();
    chk("wr4_rd_oe_2",    a_bus_oe,    0);
    chk("wr4_rd_rspv_2",  a_rsp_valid, 0);
    step();
    chk("wr4_rd_rspv_3",  a_rsp_valid, 1);
    chk("wr4_rd_rdata_3", a_rsp_rdata, 8'hC3);
    chk("wr4_rd_ready_3", a_req_ready, 1);
    a_req_write = 1'b1; a_req_wdata = 8'h99;
    step();
    a_req_valid = 1'b0;
    chk("b2b_oe",      a_bus_oe,    1);
    chk("b2b_dout",    a_bus_dout,  8'h99);
    chk("b2b_rspv",    a_rsp_valid, 0);
    step();
    step();
    chk("b2b_ready",   a_req_ready, 1);

    // 6. Request held while busy, wdata changed mid-transaction
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'h11;
    step();
    a_req_wdata = 8'h22;
    chk("h6_oe_k1",    a_bus_oe,    1);
    chk("h6_dout_k1",  a_bus_dout,  8'h11);
    step();
    chk("h6_oe_k2",    a_bus_oe,    0);
    chk("h6_dout_k2",  a_bus_dout,  8'h11);
    chk("h6_ready_k2", a_req_ready, 0);
    step();
    chk("h6_ready_k3", a_req_ready, 1);
    chk("h6_dout_k3",  a_bus_dout,  8'h11);
    step();
    a_req_valid = 1'b0;
    chk("h6_oe_2nd",   a_bus_oe,    1);
    chk("h6_dout_2nd", a_bus_dout,  8'h22);
    step();
    step();
    chk("h6_idle",     a_req_ready, 1);

    // 3. Wide windows on instance B: write 0F
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_wdata = 8'h0F;
    step();
    b_req_valid = 1'b0;
    chk("w3_oe_k1",    b_bus_oe,    1);
    chk("w3_dout_k1",  b_bus_dout,  8'h0F);
    step();
    chk("w3_oe_k2",    b_bus_oe,    1);
    step();
    chk("w3_oe_k3",    b_bus_oe,    1);
    step();
    chk("w3_oe_k4",    b_bus_oe,    0);
    chk("w3_ready_k4", b_req_ready, 0);
    step();
    chk("w3_oe_k5",    b_bus_oe,    0);
    chk("w3_ready_k5", b_req_ready, 0);
    step();
    chk("w3_ready_k6", b_req_ready, 1);
    chk("w3_oe_k6",    b_bus_oe,    0);

    // Read on instance B: response at k+TURN_CYC+2 = k+4
    b_bus_din = 8'h6E;
    b_req_valid = 1'b1; b_req_write = 1'b0;
    step();
    b_req_valid = 1'b0;
    step();
    chk("r3_rspv_k2",  b_rsp_valid, 0);
    step();
    chk("r3_rspv_k3",  b_rsp_valid, 0);
    chk("r3_busy_k3",  b_busy,      1);
    step();
    chk("r3_rspv_k4",  b_rsp_valid, 1);
    chk("r3_rdata_k4", b_rsp_rdata, 8'h6E);
    chk("r3_oe_k4",    b_bus_oe,    0);

    // 5. Reset asserted mid-DRIVE on instance A
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_wdata = 8'h77;
    step();
    a_req_valid = 1'b0;
    chk("r5_oe_pre",   a_bus_oe,    1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r5_oe_async", a_bus_oe,    0);
    chk("r5_rspv",     a_rsp_valid, 0);
    chk("r5_busy",     a_busy,      0);
    step();
    rst_n = 1'b1;
    step();
    chk("r5_ready",    a_req_ready, 1);
    chk("r5_oe_post",  a_bus_oe,    0);
    chk("r5_dout",     a_bus_dout,  8'h00);
    chk("r5_rspv_post", a_rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
